// File: rtl/spi_cmd_pkg.sv
// Shared types and field positions for the SPI command dispatcher.
package spi_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_MOTOR  = 8'h00,
        CMD_SEL    = 8'h01,
        CMD_BCAST  = 8'h02,
        CMD_BINSET = 8'h03
    } cmd_e;

    localparam logic [7:0]  RD_BIN    = 8'd3;
    localparam int unsigned MOTOR_LSB = 11;
    localparam int unsigned MOTOR_MSB = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXEC
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with a registered rising-edge pulse on the synchronised value.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              rise_q, rise_d;

    // rise_q goes high in the same cycle the last stage first shows the new 1
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], in};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/spi_cmd_dispatch.sv
// SPI command decoder and register bank: settle delay, motor periods, readback select, bin pointer.
module spi_cmd_dispatch
    import spi_cmd_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_MOTORS  = 24,
    parameter int unsigned PWM_W       = 11,
    parameter int unsigned NUM_BINS    = 640,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 11,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_ready,
    input  logic [DATA_W-1:0]             cmd_word,
    output logic [NUM_MOTORS*PWM_W-1:0]   motor_periods,
    output logic [7:0]                    rd_sel,
    output logic [$clog2(NUM_BINS)-1:0]   bin_addr,
    output logic                          exec_strobe,
    output logic                          busy,
    output logic [ERR_W-1:0]              err_count
);

    localparam int unsigned BIN_W = $clog2(NUM_BINS);
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PWM_W-1:0]        period_q [NUM_MOTORS];
    logic [PWM_W-1:0]        period_d [NUM_MOTORS];
    logic [7:0]              rd_sel_q, rd_sel_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic                    exec_q, exec_d;
    logic                    busy_q, busy_d;
    logic                    load_ev;
    logic                    err_inc;
    logic [7:0]              cmd;
    logic [7:0]              motor_idx;
    logic [15:0]             bin_req;
    logic [PWM_W-1:0]        pwm_val;
    logic                    unused_cmd_bits;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .in    (data_ready),
        .rise  (load_ev)
    );

    assign cmd             = cmd_word[DATA_W-1 -: 8];
    assign motor_idx       = cmd_word[MOTOR_MSB:MOTOR_LSB];
    assign bin_req         = cmd_word[15:0];
    assign pwm_val         = cmd_word[PWM_W-1:0];
    assign unused_cmd_bits = ^cmd_word;

    // Settle countdown, command execution and error accounting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        rd_sel_d = rd_sel_q;
        bin_d    = bin_q;
        err_inc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_ev) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(SETTLE - 1);
                end
            end
            ST_WAIT: begin
                if (load_ev) err_inc = 1'b1;
                if (cnt_q == '0) state_d = ST_EXEC;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_EXEC: begin
                if (load_ev) err_inc = 1'b1;
                state_d = ST_IDLE;
                case (cmd)
                    CMD_MOTOR: begin
                        if (32'(motor_idx) < NUM_MOTORS) begin
                            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                                if (i == 32'(motor_idx)) period_d[i] = pwm_val;
                            end
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    CMD_SEL: begin
                        rd_sel_d = cmd_word[7:0];
                        if (cmd_word[7:0] == RD_BIN) begin
                            bin_d = (32'(bin_q) == NUM_BINS - 1) ? '0 : bin_q + BIN_W'(1);
                        end
                    end
                    CMD_BCAST: begin
                        for (int unsigned i = 0; i < NUM_MOTORS; i++) period_d[i] = pwm_val;
                    end
                    CMD_BINSET: begin
                        if (32'(bin_req) < NUM_BINS) bin_d   = BIN_W'(bin_req);
                        else                         err_inc = 1'b1;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        // Overrun and command error in one cycle still count once
        err_d  = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
        exec_d = (state_d == ST_EXEC);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_sel_q <= '0;
            bin_q    <= '0;
            err_q    <= '0;
            exec_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) period_q[i] <= PWM_W'(1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
            bin_q    <= bin_d;
            err_q    <= err_d;
            exec_q   <= exec_d;
            busy_q   <= busy_d;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) period_q[i] <= period_d[i];
        end
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_flat
        assign motor_periods[g*PWM_W +: PWM_W] = period_q[g];
    end

    assign rd_sel      = rd_sel_q;
    assign bin_addr    = bin_q;
    assign err_count   = err_q;
    assign exec_strobe = exec_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Scoreboard bench for spi_cmd_dispatch: model snapshots queued at issue, checked after each exec_strobe.
module tb_spi_cmd_dispatch;

    localparam int NM = 24;
    localparam int PW = 11;
    localparam int NB = 640;
    localparam int SS = 2;
    localparam int ST = 11;
    localparam int EW = 8;
    localparam int DW = 32;
    localparam int LAT = SS + ST + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              data_ready;
    logic [DW-1:0]     cmd_word;
    logic [NM*PW-1:0]  motor_periods;
    logic [7:0]        rd_sel;
    logic [9:0]        bin_addr;
    logic              exec_strobe;
    logic              busy;
    logic [EW-1:0]     err_count;

    typedef struct packed {
        logic [NM*PW-1:0] per;
        logic [7:0]       rd;
        logic [9:0]       bin;
        logic [7:0]       err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   m_per[NM];
    int   m_rd, m_bin, m_err;
    int   tests = 0;
    int   fails = 0;
    logic [NM*PW-1:0] ones_vec;

    spi_cmd_dispatch #(
        .DATA_W(DW), .NUM_MOTORS(NM), .PWM_W(PW), .NUM_BINS(NB),
        .SYNC_STAGES(SS), .SETTLE(ST), .ERR_W(EW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_ready    (data_ready),
        .cmd_word      (cmd_word),
        .motor_periods (motor_periods),
        .rd_sel        (rd_sel),
        .bin_addr      (bin_addr),
        .exec_strobe   (exec_strobe),
        .busy          (busy),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    function automatic exp_t snapshot();
        exp_t s;
        for (int i = 0; i < NM; i++) s.per[i*PW +: PW] = PW'(m_per[i]);
        s.rd  = 8'(m_rd);
        s.bin = 10'(m_bin);
        s.err = 8'(m_err);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) m_per[i] = 1;
        m_rd  = 0;
        m_bin = 0;
        m_err = 0;
        sb_q.delete();
    endtask

    task automatic err_bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_cmd(input logic [31:0] w, input int ovr);
        logic [7:0] c;
        int mi, p;
        c  = w[31:24];
        mi = int'(w[18:11]);
        p  = int'(w[15:0]);
        if (ovr != 0) err_bump();
        case (c)
            8'h00: if (mi < NM) m_per[mi] = int'(w[10:0]); else err_bump();
            8'h01: begin
                m_rd = int'(w[7:0]);
                if (w[7:0] == 8'd3) m_bin = (m_bin + 1) % NB;
            end
            8'h02: for (int i = 0; i < NM; i++) m_per[i] = int'(w[10:0]);
            8'h03: if (p < NB) m_bin = p; else err_bump();
            default: err_bump();
        endcase
        sb_q.push_back(snapshot());
    endtask

    // Issue one command and return the number of posedges until exec_strobe (0 = timeout)
    task automatic run_cmd(input logic [31:0] w, output int lat);
        model_cmd(w, 0);
        @(negedge clk);
        cmd_word   = w;
        data_ready = 1'b1;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            data_ready = 1'b0;
            if (exec_strobe === 1'b1) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    // Scoreboard consumer: state one cycle after each exec_strobe must match the queued snapshot
    always begin
        @(posedge clk); #1;
        if (exec_strobe === 1'b1) begin
            @(posedge clk); #1;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_exec: exec_strobe with no pending command at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (motor_periods !== mon_e.per) begin
                    fails++;
                    $display("FAIL sb_periods: got %h expected %h", motor_periods, mon_e.per);
                end
                tests++;
                if (rd_sel !== mon_e.rd) begin
                    fails++;
                    $display("FAIL sb_rd_sel: got %0d expected %0d", rd_sel, mon_e.rd);
                end
                tests++;
                if (bin_addr !== mon_e.bin) begin
                    fails++;
                    $display("FAIL sb_bin_addr: got %0d expected %0d", bin_addr, mon_e.bin);
                end
                tests++;
                if (err_count !== mon_e.err) begin
                    fails++;
                    $display("FAIL sb_err_count: got %0d expected %0d", err_count, mon_e.err);
                end
            end
        end
    end

    task automatic test_reset();
        reset      = 1'b1;
        data_ready = 1'b0;
        cmd_word   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (motor_periods !== ones_vec) begin
            fails++;
            $display("FAIL reset_periods: got %h expected %h", motor_periods, ones_vec);
        end
        tests++;
        if (rd_sel !== 8'd0 || bin_addr !== 10'd0 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_regs: rd_sel=%0d bin=%0d err=%0d expected 0/0/0", rd_sel, bin_addr, err_count);
        end
        tests++;
        if (busy !== 1'b0 || exec_strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b exec=%b expected 0/0", busy, exec_strobe);
        end
    endtask

    task automatic test_motor_write();
        int lat;
        run_cmd(32'h0000_2BE8, lat);
        tests++;
        if (lat != LAT) begin
            fails++;
            $display("FAIL motor_latency: got %0d cycles expected %0d", lat, LAT);
        end
        tests++;
        if (motor_periods[5*PW +: PW] !== 11'd1000 || motor_periods[4*PW +: PW] !== 11'd1) begin
            fails++;
            $display("FAIL motor5_period: got %0d (motor4 %0d) expected 1000 (1)",
                     motor_periods[5*PW +: PW], motor_periods[4*PW +: PW]);
        end
    endtask

    task automatic test_bin_pointer();
        int lat;
        int timeouts = 0;
        for (int i = 0; i < 641; i++) begin
            run_cmd(32'h0100_0003, lat);
            if (lat == 0) timeouts++;
        end
        tests++;
        if (timeouts != 0) begin
            fails++;
            $display("FAIL bin_timeouts: got %0d timeouts expected 0", timeouts);
        end
        tests++;
        if (bin_addr !== 10'd1 || rd_sel !== 8'd3) begin
            fails++;
            $display("FAIL bin_wrap: bin=%0d rd_sel=%0d expected 1/3", bin_addr, rd_sel);
        end
        run_cmd(32'h0300_027F, lat);
        tests++;
        if (bin_addr !== 10'd639) begin
            fails++;
            $display("FAIL binset_639: got %0d expected 639", bin_addr);
        end
        run_cmd(32'h0300_0280, lat);
        tests++;
        if (bin_addr !== 10'd639 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL binset_640: bin=%0d err=%0d expected 639/1", bin_addr, err_count);
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [NM*PW-1:0] sevens;
        for (int i = 0; i < NM; i++) sevens[i*PW +: PW] = 11'd7;
        run_cmd(32'h0200_0007, lat);
        tests++;
        if (motor_periods !== sevens) begin
            fails++;
            $display("FAIL broadcast: got %h expected %h", motor_periods, sevens);
        end
        run_cmd(32'h0000_C005, lat);
        tests++;
        if (motor_periods !== sevens || err_count !== 8'd2) begin
            fails++;
            $display("FAIL motor24: err=%0d expected 2, periods %h expected %h", err_count, motor_periods, sevens);
        end
        run_cmd(32'hFF00_0000, lat);
        tests++;
        if (err_count !== 8'd3) begin
            fails++;
            $display("FAIL unknown_cmd: err=%0d expected 3", err_count);
        end
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        model_cmd(32'h0000_0123, 1);
        @(negedge clk);
        cmd_word   = 32'h0000_0123;
        data_ready = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) data_ready = 1'b0;
            if (n == 3) data_ready = 1'b1;
            if (n == 4) data_ready = 1'b0;
            if (n == 6) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL overrun_busy: got %b expected 1", busy);
                end
            end
            if (exec_strobe === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 1) begin
            fails++;
            $display("FAIL overrun_strobes: got %0d expected 1", strobes);
        end
        tests++;
        if (err_count !== 8'd4 || motor_periods[0 +: PW] !== 11'h123 || busy !== 1'b0) begin
            fails++;
            $display("FAIL overrun_state: err=%0d p0=%h busy=%b expected 4/123/0",
                     err_count, motor_periods[0 +: PW], busy);
        end
    endtask

    task automatic test_reset_abort();
        int strobes = 0;
        @(negedge clk);
        cmd_word   = 32'h0000_184D;
        data_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n == 1) data_ready = 1'b0;
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (exec_strobe === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 0) begin
            fails++;
            $display("FAIL abort_strobe: got %0d strobes expected 0", strobes);
        end
        tests++;
        if (motor_periods !== ones_vec || err_count !== 8'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: periods %h err=%0d busy=%b expected all 1/0/0",
                     motor_periods, err_count, busy);
        end
    endtask

    task automatic test_err_saturate();
        int lat;
        int timeouts = 0;
        for (int i = 0; i < 257; i++) begin
            run_cmd(32'hFF00_0000, lat);
            if (lat == 0) timeouts++;
        end
        tests++;
        if (timeouts != 0) begin
            fails++;
            $display("FAIL sat_timeouts: got %0d timeouts expected 0", timeouts);
        end
        tests++;
        if (err_count !== 8'hFF) begin
            fails++;
            $display("FAIL err_saturate: got %0d expected 255", err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) ones_vec[i*PW +: PW] = 11'd1;
        test_reset();
        test_motor_write();
        test_bin_pointer();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_err_saturate();
        repeat (5) @(posedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending entries expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
